// File: rtl/prog_run_ctrl.sv
// Program run controller: arms on Start rise, launches a run on Start fall, counts run cycles.
// Ends a run on Halt, optional timeout or abort. State outputs are registered; CountEn follows Stall combinationally.
module prog_run_ctrl #(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 0,
  parameter int NUM_PROGS = 3,
  localparam int PROG_W   = (NUM_PROGS > 2) ? $clog2(NUM_PROGS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [PROG_W-1:0] i_prog_sel,
  input  logic              i_halt,
  input  logic              i_stall,
  output logic              o_count_en,
  output logic              o_prog_load,
  output logic [PROG_W-1:0] o_active_prog,
  output logic              o_running,
  output logic              o_done,
  output logic              o_timed_out,
  output logic [CNT_W-1:0]  o_cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [PROG_W-1:0] MAX_PROG = PROG_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]  TO_M1    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  logic                r_start_q;
  logic                r_prog_load;
  logic                r_timed_out;
  logic [PROG_W-1:0]   r_active_prog;
  logic [CNT_W-1:0]    r_cycle_count;

  logic                w_rise;
  logic                w_fall;
  logic                w_count_en;
  logic [PROG_W-1:0]   w_sel_clamped;

  assign w_rise        = i_start & ~r_start_q;
  assign w_fall        = ~i_start & r_start_q;
  assign w_sel_clamped = (int'(i_prog_sel) >= NUM_PROGS) ? MAX_PROG : i_prog_sel;

  // Reset gates CountEn directly because state only clears on the next edge.
  assign w_count_en = (r_state == S_RUN) & ~i_stall & ~r_prog_load & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_prog_load   <= 1'b0;
      r_timed_out   <= 1'b0;
      r_active_prog <= '0;
      r_cycle_count <= '0;
    end else begin
      r_start_q   <= i_start;
      r_prog_load <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_rise) begin
            r_state       <= S_ARMED;
            r_active_prog <= w_sel_clamped;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_fall) begin
            r_state     <= S_RUN;
            r_prog_load <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort beats Halt, and Halt beats timeout.
          if (w_rise) begin
            r_state       <= S_ARMED;
            r_active_prog <= w_sel_clamped;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
          end else if (i_halt) begin
            r_state <= S_DONE;
          end else if (w_count_en) begin
            if (TIMEOUT != 0 && r_cycle_count == TO_M1) begin
              r_state       <= S_DONE;
              r_timed_out   <= 1'b1;
              r_cycle_count <= r_cycle_count + CNT_ONE;
            end else if (r_cycle_count != '1) begin
              r_cycle_count <= r_cycle_count + CNT_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_count_en    = w_count_en;
  assign o_prog_load   = r_prog_load;
  assign o_active_prog = r_active_prog;
  assign o_running     = (r_state == S_RUN);
  assign o_done        = (r_state == S_DONE);
  assign o_timed_out   = r_timed_out;
  assign o_cycle_count = r_cycle_count;

endmodule
